// File: rtl/hdmi_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_pkg
// Shared definitions for the HDMI timing / test-pattern generator:
//   - standard timing constant sets (1080p60, 720p60, 480p60)
//   - pattern mode and FSM state encodings
//   - the eight colour-bar RGB888 constants and a lookup helper
// -----------------------------------------------------------------------------
package hdmi_pkg;

  // Pattern source selection, encoded exactly as the `mode` input
  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_e;

  // Generator run state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One complete video timing description
  typedef struct packed {
    int unsigned h_active;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_active;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
    logic        h_pol;
    logic        v_pol;
  } timing_t;

  localparam timing_t TIMING_1080P60 = '{
    h_active: 32'd1920, h_front: 32'd88,  h_sync: 32'd44, h_back: 32'd148,
    v_active: 32'd1080, v_front: 32'd4,   v_sync: 32'd5,  v_back: 32'd36,
    h_pol: 1'b1, v_pol: 1'b1
  };

  localparam timing_t TIMING_720P60 = '{
    h_active: 32'd1280, h_front: 32'd110, h_sync: 32'd40, h_back: 32'd220,
    v_active: 32'd720,  v_front: 32'd5,   v_sync: 32'd5,  v_back: 32'd20,
    h_pol: 1'b1, v_pol: 1'b1
  };

  localparam timing_t TIMING_480P60 = '{
    h_active: 32'd720,  h_front: 32'd16,  h_sync: 32'd62, h_back: 32'd60,
    v_active: 32'd480,  v_front: 32'd9,   v_sync: 32'd6,  v_back: 32'd30,
    h_pol: 1'b0, v_pol: 1'b0
  };

  // Colour bars, left to right
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Map a bar index (0 = leftmost) to its RGB888 colour
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      3'd7:    c = BAR_BLACK;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_pattern_gen.sv
// -----------------------------------------------------------------------------
// hdmi_pattern_gen
// Produces the registered RGB888 pixel for the raster position that the top
// level is currently decoding, so `o_data` lines up with the registered `de`.
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   i_mode       frame-stable (shadowed) pattern select
//   i_color      frame-stable (shadowed) solid colour
//   i_x, i_y     pre-output active coordinates (0 outside the active region)
//   i_de         pre-output data enable
//   o_data       registered pixel, {R,G,B}; 0 whenever i_de was low
// -----------------------------------------------------------------------------
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int CW       = 12,
  parameter int CHK_LOG2 = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  mode_e         i_mode,
  input  logic [23:0]   i_color,
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  input  logic          i_de,
  output logic [23:0]   o_data
);

  // A zero-width bar is meaningless; very narrow rasters fall back to 1 pixel
  localparam int            BAR_W    = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
  localparam logic [CW-1:0] BAR_W_M1 = CW'(BAR_W - 1);

  logic [CW-1:0] r_bar_cnt;
  logic [2:0]    r_bar_idx;
  logic [23:0]   w_pix;
  logic          w_chk_white;
  logic          w_unused_bits;

  // Only a few coordinate bits feed the patterns; fold the rest so they are consumed
  assign w_unused_bits = ^{i_x, i_y};

  // Checkerboard square parity from the selected coordinate bit
  assign w_chk_white = i_x[CHK_LOG2] ^ i_y[CHK_LOG2];

  // Pixel colour for the position being decoded this cycle
  always_comb begin
    w_pix = 24'h000000;
    if (i_de) begin
      case (i_mode)
        MODE_SOLID: w_pix = i_color;
        MODE_BARS:  w_pix = bar_color(r_bar_idx);
        MODE_CHECK: w_pix = w_chk_white ? BAR_WHITE : BAR_BLACK;
        MODE_RAMP:  w_pix = {3{i_x[7:0]}};
        default:    w_pix = 24'h000000;
      endcase
    end else begin
      w_pix = 24'h000000;
    end
  end

  // Bar index tracker: a BAR_W down-counter steps the index, which then sticks
  // at black so any H_ACTIVE % 8 remainder pixels widen the last bar
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_cnt <= BAR_W_M1;
      r_bar_idx <= 3'd0;
    end else if (!i_de) begin
      r_bar_cnt <= BAR_W_M1;
      r_bar_idx <= 3'd0;
    end else if (r_bar_cnt == {CW{1'b0}}) begin
      r_bar_cnt <= BAR_W_M1;
      if (r_bar_idx != 3'd7) begin
        r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_idx <= r_bar_idx;
      end
    end else begin
      r_bar_cnt <= r_bar_cnt - CW'(1);
      r_bar_idx <= r_bar_idx;
    end
  end

  // Output pixel register, aligned with the top-level `de` register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= 24'h000000;
    end else begin
      o_data <= w_pix;
    end
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// -----------------------------------------------------------------------------
// hdmi_timing_gen
// Parametrised video timing and test-pattern generator driving the HDMI
// PHY/encoder. Line and frame order from counter 0 is: sync, back porch,
// active, front porch.
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   en           run request; dropping it ends generation at the next frame wrap
//   mode         pattern: 0 solid, 1 colour bars, 2 checkerboard, 3 grey ramp
//   solid_color  RGB888 colour for the solid pattern
//   data         registered RGB888 pixel {R,G,B}, 0 outside the active region
//   h_sync       horizontal sync, asserted level H_SYNC_POL
//   v_sync       vertical sync, asserted level V_SYNC_POL
//   de           data enable, high only in the active region
//   x, y         active column / line, 0 while `de` is low
//   frame_start  one-cycle pulse for counter position (0,0)
//   clk_out      inverted pixel clock for the PHY
// All outputs except clk_out are registered and show the decode of the counter
// position held on the previous cycle.
// -----------------------------------------------------------------------------
module hdmi_timing_gen
  import hdmi_pkg::*;
#(
  parameter int   H_ACTIVE      = 1920,
  parameter int   H_FRONT_PORCH = 88,
  parameter int   H_SYNC        = 44,
  parameter int   H_BACK_PORCH  = 148,
  parameter int   V_ACTIVE      = 1080,
  parameter int   V_FRONT_PORCH = 4,
  parameter int   V_SYNC        = 5,
  parameter int   V_BACK_PORCH  = 36,
  parameter logic H_SYNC_POL    = 1'b1,
  parameter logic V_SYNC_POL    = 1'b1,
  parameter int   CW            = 12,
  parameter int   CHK_LOG2      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_color,
  output logic [23:0]   data,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          clk_out
);

  localparam int H_TOTAL = H_SYNC + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;
  localparam int V_TOTAL = V_SYNC + V_BACK_PORCH + V_ACTIVE + V_FRONT_PORCH;
  localparam int H_START = H_SYNC + H_BACK_PORCH;
  localparam int V_START = V_SYNC + V_BACK_PORCH;

  localparam logic [CW-1:0] L_H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] L_V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] L_H_SYNC     = CW'(H_SYNC);
  localparam logic [CW-1:0] L_V_SYNC     = CW'(V_SYNC);
  localparam logic [CW-1:0] L_H_START    = CW'(H_START);
  localparam logic [CW-1:0] L_V_START    = CW'(V_START);
  // Inclusive end of the active window, so a zero front porch cannot overflow CW
  localparam logic [CW-1:0] L_H_ACT_LAST = CW'(H_START + H_ACTIVE - 1);
  localparam logic [CW-1:0] L_V_ACT_LAST = CW'(V_START + V_ACTIVE - 1);

  state_e        r_state;
  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  mode_e         r_shadow_mode;
  logic [23:0]   r_shadow_color;

  logic          w_adv;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_frame_wrap;
  logic          w_origin;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_pre_de;
  logic [CW-1:0] w_pre_x;
  logic [CW-1:0] w_pre_y;
  logic          w_h_sync_lvl;
  logic          w_v_sync_lvl;

  // The raster moves while running, and also on the IDLE cycle that sees `en`,
  // so position (0,0) is emitted on the very first enabled edge
  assign w_adv        = (r_state == ST_RUN) || en;
  assign w_h_wrap     = (r_hc == L_H_LAST);
  assign w_v_wrap     = (r_vc == L_V_LAST);
  assign w_frame_wrap = w_h_wrap && w_v_wrap;
  assign w_origin     = (r_hc == {CW{1'b0}}) && (r_vc == {CW{1'b0}});

  // Pre-output decode of the current counter position
  always_comb begin
    w_h_act      = (r_hc >= L_H_START) && (r_hc <= L_H_ACT_LAST);
    w_v_act      = (r_vc >= L_V_START) && (r_vc <= L_V_ACT_LAST);
    w_pre_de     = 1'b0;
    w_pre_x      = {CW{1'b0}};
    w_pre_y      = {CW{1'b0}};
    w_h_sync_lvl = ~H_SYNC_POL;
    w_v_sync_lvl = ~V_SYNC_POL;
    if (w_adv) begin
      w_pre_de     = w_h_act && w_v_act;
      w_h_sync_lvl = (r_hc < L_H_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
      w_v_sync_lvl = (r_vc < L_V_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
    end else begin
      w_pre_de     = 1'b0;
      w_h_sync_lvl = ~H_SYNC_POL;
      w_v_sync_lvl = ~V_SYNC_POL;
    end
    if (w_pre_de) begin
      w_pre_x = r_hc - L_H_START;
      w_pre_y = r_vc - L_V_START;
    end else begin
      w_pre_x = {CW{1'b0}};
      w_pre_y = {CW{1'b0}};
    end
  end

  // IDLE/RUN FSM with the raster counters and registered timing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hc        <= {CW{1'b0}};
      r_vc        <= {CW{1'b0}};
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
      de          <= 1'b0;
      x           <= {CW{1'b0}};
      y           <= {CW{1'b0}};
      frame_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Only leave at the frame wrap so a dropped `en` finishes the frame
          if (w_frame_wrap && !en) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_adv) begin
        if (w_h_wrap) begin
          r_hc <= {CW{1'b0}};
          if (w_v_wrap) begin
            r_vc <= {CW{1'b0}};
          end else begin
            r_vc <= r_vc + CW'(1);
          end
        end else begin
          r_hc <= r_hc + CW'(1);
          r_vc <= r_vc;
        end
      end else begin
        r_hc <= {CW{1'b0}};
        r_vc <= {CW{1'b0}};
      end

      h_sync      <= w_h_sync_lvl;
      v_sync      <= w_v_sync_lvl;
      de          <= w_pre_de;
      x           <= w_pre_x;
      y           <= w_pre_y;
      frame_start <= w_adv && w_origin;
    end
  end

  // Pattern settings are captured only at the frame origin so every frame is uniform
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_mode  <= MODE_SOLID;
      r_shadow_color <= 24'h000000;
    end else if (w_adv && w_origin) begin
      r_shadow_mode  <= mode_e'(mode);
      r_shadow_color <= solid_color;
    end else begin
      r_shadow_mode  <= r_shadow_mode;
      r_shadow_color <= r_shadow_color;
    end
  end

  hdmi_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .CW       (CW),
    .CHK_LOG2 (CHK_LOG2)
  ) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_mode  (r_shadow_mode),
    .i_color (r_shadow_color),
    .i_x     (w_pre_x),
    .i_y     (w_pre_y),
    .i_de    (w_pre_de),
    .o_data  (data)
  );

  // The PHY wants the inverted pixel clock
  assign clk_out = ~clk;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_hdmi_timing_gen
// Small raster (H 16/2/3/4 -> 25 cycles per line, V 4/1/2/1 -> 8 lines) with
// negative horizontal sync. Outputs are compared every cycle against a model
// that derives the expected raster from the frame-relative cycle index.
// -----------------------------------------------------------------------------
module tb_hdmi_timing_gen;

  localparam int   HA   = 16;
  localparam int   HFP  = 2;
  localparam int   HS   = 3;
  localparam int   HBP  = 4;
  localparam int   VA   = 4;
  localparam int   VFP  = 1;
  localparam int   VS   = 2;
  localparam int   VBP  = 1;
  localparam int   HT   = 25;
  localparam int   VT   = 8;
  localparam int   CHK  = 2;
  localparam int   CWB  = 12;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b1;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [23:0]    solid_color = 24'h000000;
  logic [23:0]    data;
  logic           h_sync;
  logic           v_sync;
  logic           de;
  logic [CWB-1:0] x;
  logic [CWB-1:0] y;
  logic           frame_start;
  logic           clk_out;

  hdmi_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP),
    .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .CW(CWB), .CHK_LOG2(CHK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_color(solid_color),
    .data(data), .h_sync(h_sync), .v_sync(v_sync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: running flag, cycle index within the frame, captured pattern settings
  bit          m_run;
  int          m_p;
  int          m_smode;
  logic [23:0] m_scol;

  logic        e_hs, e_vs, e_de, e_fs;
  logic [23:0] e_data;
  int          e_x, e_y;
  int          cnt_de, cnt_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int md, input logic [23:0] col,
                                            input int px, input int py);
    int          bar;
    logic [7:0]  g;
    logic [23:0] r;
    case (md)
      0: r = col;
      1: begin
        bar = px / (HA / 8);
        if (bar > 7) bar = 7;
        r = BARS[bar];
      end
      2: r = ((((px >> CHK) ^ (py >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: begin
        g = px[7:0];
        r = {g, g, g};
      end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_run   = 1'b0;
    m_p     = 0;
    m_smode = 0;
    m_scol  = 24'h000000;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hsync"}, {31'd0, h_sync}, {31'd0, ~HPOL});
    chk({tag, "_vsync"}, {31'd0, v_sync}, {31'd0, ~VPOL});
    chk({tag, "_de"},    {31'd0, de}, 32'd0);
    chk({tag, "_data"},  {8'd0, data}, 32'd0);
    chk({tag, "_x"},     {20'd0, x}, 32'd0);
    chk({tag, "_y"},     {20'd0, y}, 32'd0);
    chk({tag, "_fs"},    {31'd0, frame_start}, 32'd0);
  endtask

  // One clock: predict from the inputs now applied, clock, then compare
  task automatic step();
    int hc, vc;
    if (m_run || en) begin
      hc = m_p % HT;
      vc = m_p / HT;
      if (m_p == 0) begin
        m_smode = int'(mode);
        m_scol  = solid_color;
      end
      e_hs   = (hc < HS) ? HPOL : ~HPOL;
      e_vs   = (vc < VS) ? VPOL : ~VPOL;
      e_de   = (hc >= HS + HBP) && (hc < HS + HBP + HA) && (vc >= VS + VBP) && (vc < VS + VBP + VA);
      e_x    = e_de ? hc - (HS + HBP) : 0;
      e_y    = e_de ? vc - (VS + VBP) : 0;
      e_fs   = (m_p == 0);
      e_data = e_de ? ref_pixel(m_smode, m_scol, e_x, e_y) : 24'h000000;
      if (m_p == HT * VT - 1) begin
        m_p   = 0;
        m_run = en;
      end else begin
        m_p   = m_p + 1;
        m_run = 1'b1;
      end
    end else begin
      e_hs = ~HPOL; e_vs = ~VPOL; e_de = 1'b0; e_x = 0; e_y = 0; e_fs = 1'b0;
      e_data = 24'h000000;
    end
    @(posedge clk);
    #1;
    chk("hsync", {31'd0, h_sync}, {31'd0, e_hs});
    chk("vsync", {31'd0, v_sync}, {31'd0, e_vs});
    chk("de",    {31'd0, de}, {31'd0, e_de});
    chk("x",     {20'd0, x}, e_x);
    chk("y",     {20'd0, y}, e_y);
    chk("fs",    {31'd0, frame_start}, {31'd0, e_fs});
    chk("data",  {8'd0, data}, {8'd0, e_data});
    cnt_de = cnt_de + int'(de);
    cnt_hs = cnt_hs + int'(h_sync == HPOL);
  endtask

  initial begin
    model_reset();
    cnt_de = 0;
    cnt_hs = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst0");
    chk("clk_out", {31'd0, clk_out}, {31'd0, ~clk});
    rst_n = 1'b1;

    // Idle with en low: nothing moves
    repeat (5) step();

    // Frame of colour bars, with per-frame totals
    en = 1'b1;
    mode = 2'd1;
    cnt_de = 0;
    cnt_hs = 0;
    repeat (HT * VT) step();
    chk("de_per_frame", cnt_de, 32'd64);
    chk("hs_per_frame", cnt_hs, 32'd24);

    // Solid frame; switching to checkerboard mid-frame waits for the next frame
    mode = 2'd0;
    solid_color = 24'h123456;
    repeat (100) step();
    mode = 2'd2;
    solid_color = 24'hABCDEF;
    repeat (100) step();
    repeat (HT * VT) step();

    // Randomised pattern settings
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 30) == 0) begin
        mode = 2'($urandom_range(0, 3));
        solid_color = 24'($urandom);
      end
      step();
    end

    // Drop en mid-frame: the frame completes, then the block idles
    repeat (37) step();
    en = 1'b0;
    repeat (HT * VT + 60) step();

    // Restart, then reset asynchronously mid-line
    en = 1'b1;
    mode = 2'd3;
    repeat (HT * 4 + 11) step();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    rst_n = 1'b1;

    // Random run with occasional en drops
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 20) == 0) begin
        mode = 2'($urandom_range(0, 3));
        solid_color = 24'($urandom);
      end
      if ($urandom_range(0, 50) == 0) begin
        en = ~en;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
